// File: rtl/gate_sweep_pkg.sv
// Shared types and golden model for the gate-cell self-test sequencer.
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Bit positions inside the {not,and,or} result / mismatch vectors
    localparam int unsigned MASK_NOT = 2;
    localparam int unsigned MASK_AND = 1;
    localparam int unsigned MASK_OR  = 0;

    function automatic logic [2:0] golden(input logic a, input logic b);
        logic [2:0] r;
        r           = '0;
        r[MASK_NOT] = ~a;
        r[MASK_AND] = a & b;
        r[MASK_OR]  = a | b;
        return r;
    endfunction

endpackage

// File: rtl/gate_sweep_check.sv
// Combinational compare of observed gate outputs against the golden truth table.
module gate_sweep_check
    import gate_sweep_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       obs_not_i,
    input  logic       obs_and_i,
    input  logic       obs_or_i,
    output logic [2:0] mismatch_o
);

    logic [2:0] obs;

    always_comb begin
        obs           = '0;
        obs[MASK_NOT] = obs_not_i;
        obs[MASK_AND] = obs_and_i;
        obs[MASK_OR]  = obs_or_i;
        mismatch_o    = obs ^ golden(a_i, b_i);
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps all A/B vectors PASSES times and checks NOT/AND/OR outputs.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             drive_A,
    output logic             drive_B,
    input  logic             obs_not,
    input  logic             obs_and,
    input  logic             obs_or,
    output logic             busy,
    output logic             done,
    output logic             pass_ok,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic [2:0]       fail_mask
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [PW-1:0]    pass_q, pass_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             drive_a_q, drive_a_d;
    logic             drive_b_q, drive_b_d;
    logic             done_q, done_d;
    logic             pass_ok_q, pass_ok_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [1:0]       fail_vec_q, fail_vec_d;
    logic [2:0]       fail_mask_q, fail_mask_d;
    logic             seen_q, seen_d;
    logic [2:0]       mismatch;

    gate_sweep_check u_check (
        .a_i        (drive_a_q),
        .b_i        (drive_b_q),
        .obs_not_i  (obs_not),
        .obs_and_i  (obs_and),
        .obs_or_i   (obs_or),
        .mismatch_o (mismatch)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        pass_d      = pass_q;
        settle_d    = settle_q;
        drive_a_d   = drive_a_q;
        drive_b_d   = drive_b_q;
        done_d      = 1'b0;
        pass_ok_d   = pass_ok_q;
        err_d       = err_q;
        fail_vec_d  = fail_vec_q;
        fail_mask_d = fail_mask_q;
        seen_d      = seen_q;

        // Abort outranks start; results are only wiped when not mid-run
        if (abort) begin
            state_d   = IDLE;
            drive_a_d = 1'b0;
            drive_b_d = 1'b0;
            vec_d     = '0;
            pass_d    = '0;
            settle_d  = '0;
            if (state_q == IDLE || state_q == DONE) begin
                err_d       = '0;
                fail_vec_d  = '0;
                fail_mask_d = '0;
                pass_ok_d   = 1'b0;
                seen_d      = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        err_d       = '0;
                        fail_vec_d  = '0;
                        fail_mask_d = '0;
                        pass_ok_d   = 1'b0;
                        seen_d      = 1'b0;
                        vec_d       = '0;
                        pass_d      = '0;
                        drive_a_d   = 1'b0;
                        drive_b_d   = 1'b0;
                        state_d     = APPLY;
                    end
                end
                APPLY: begin
                    settle_d = '0;
                    state_d  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = CHECK;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (|mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!seen_q) begin
                            fail_vec_d  = {drive_a_q, drive_b_q};
                            fail_mask_d = mismatch;
                            seen_d      = 1'b1;
                        end
                    end
                    if (vec_q != 2'd3) begin
                        vec_d     = vec_q + 2'd1;
                        drive_a_d = vec_d[1];
                        drive_b_d = vec_d[0];
                        state_d   = APPLY;
                    end else if (pass_q != PASS_LAST) begin
                        vec_d     = '0;
                        pass_d    = pass_q + 1'b1;
                        drive_a_d = 1'b0;
                        drive_b_d = 1'b0;
                        state_d   = APPLY;
                    end else begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        pass_ok_d = (err_d == '0);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            pass_q      <= '0;
            settle_q    <= '0;
            drive_a_q   <= 1'b0;
            drive_b_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_ok_q   <= 1'b0;
            err_q       <= '0;
            fail_vec_q  <= '0;
            fail_mask_q <= '0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            pass_q      <= pass_d;
            settle_q    <= settle_d;
            drive_a_q   <= drive_a_d;
            drive_b_q   <= drive_b_d;
            done_q      <= done_d;
            pass_ok_q   <= pass_ok_d;
            err_q       <= err_d;
            fail_vec_q  <= fail_vec_d;
            fail_mask_q <= fail_mask_d;
            seen_q      <= seen_d;
        end
    end

    assign drive_A   = drive_a_q;
    assign drive_B   = drive_b_q;
    assign busy      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
    assign done      = done_q;
    assign pass_ok   = pass_ok_q;
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;

endmodule
